// File: rtl/vx_csr_bank.sv
// Per-core CSR bank: per-warp fcsr/mscratch/mepc and hi-latches, global cycle/instret counters.
// Latency: one cycle from request accept to registered response; frm lookup is combinational.
// Backpressure: req_ready = ~rsp_valid | rsp_ready, so a stalled response holds the request port.
// Ports: req_* (valid/ready CSR access), rsp_* (registered result), fflags_* (FPU flag accumulate),
//        cmt_*/busy (counter events), frm_wid/frm (rounding-mode lookup).
module vx_csr_bank #(
  parameter int CORE_ID     = 0,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int CTR_WIDTH   = 48,
  parameter int CMT_SIZE_W  = 3,
  localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [11:0]           req_addr,
  input  logic [NW_BITS-1:0]    req_wid,
  input  logic [31:0]           req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_data,
  output logic [NW_BITS-1:0]    rsp_wid,
  output logic                  rsp_illegal,
  input  logic                  fflags_valid,
  input  logic [NW_BITS-1:0]    fflags_wid,
  input  logic [4:0]            fflags,
  input  logic                  cmt_valid,
  input  logic [CMT_SIZE_W-1:0] cmt_size,
  input  logic                  busy,
  input  logic [NW_BITS-1:0]    frm_wid,
  output logic [2:0]            frm
);

  localparam int HI_W = CTR_WIDTH - 32;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [11:0] A_FFLAGS    = 12'h001;
  localparam logic [11:0] A_FRM       = 12'h002;
  localparam logic [11:0] A_FCSR      = 12'h003;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLE_H   = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRET_H = 12'hC82;
  localparam logic [11:0] A_NT        = 12'hCC0;
  localparam logic [11:0] A_NW        = 12'hCC1;
  localparam logic [11:0] A_WTID      = 12'hCC3;
  localparam logic [11:0] A_GWID      = 12'hCC4;
  localparam logic [11:0] A_GCID      = 12'hCC5;

  logic [7:0]           fcsr     [NUM_WARPS];
  logic [7:0]           fcsr_nxt [NUM_WARPS];
  logic [31:0]          mscratch [NUM_WARPS];
  logic [31:0]          mepc     [NUM_WARPS];
  logic [HI_W-1:0]      cyc_hi   [NUM_WARPS];
  logic [HI_W-1:0]      ins_hi   [NUM_WARPS];
  logic [CTR_WIDTH-1:0] cycle;
  logic [CTR_WIDTH-1:0] instret;

  logic        accept;
  logic        known;
  logic        ro;
  logic        mod_req;
  logic        illegal;
  logic        wr_en;
  logic [31:0] old_val;
  logic [31:0] new_val;

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;

  // SET/CLEAR with a zero operand is a pure read (rs1 = x0), legal even on read-only CSRs.
  assign mod_req = (req_op == OP_WRITE) | ((req_op != OP_READ) & (req_data != 32'd0));
  assign illegal = ~known | (ro & mod_req);
  assign wr_en   = accept & mod_req & ~illegal;

  assign frm = fcsr[frm_wid][7:5];

  always_comb begin
    old_val = '0;
    known   = 1'b1;
    ro      = 1'b0;
    case (req_addr)
      A_FFLAGS:    old_val = {27'd0, fcsr[req_wid][4:0]};
      A_FRM:       old_val = {29'd0, fcsr[req_wid][7:5]};
      A_FCSR:      old_val = {24'd0, fcsr[req_wid]};
      A_MSCRATCH:  old_val = mscratch[req_wid];
      A_MEPC:      old_val = mepc[req_wid];
      A_CYCLE:     begin ro = 1'b1; old_val = cycle[31:0]; end
      A_CYCLE_H:   begin ro = 1'b1; old_val = 32'(cyc_hi[req_wid]); end
      A_INSTRET:   begin ro = 1'b1; old_val = instret[31:0]; end
      A_INSTRET_H: begin ro = 1'b1; old_val = 32'(ins_hi[req_wid]); end
      A_NT:        begin ro = 1'b1; old_val = 32'(NUM_THREADS); end
      A_NW:        begin ro = 1'b1; old_val = 32'(NUM_WARPS); end
      A_WTID:      begin ro = 1'b1; old_val = 32'(req_wid); end
      A_GWID:      begin ro = 1'b1; old_val = 32'(CORE_ID * NUM_WARPS) + 32'(req_wid); end
      A_GCID:      begin ro = 1'b1; old_val = 32'(CORE_ID); end
      default:     known = 1'b0;
    endcase
  end

  always_comb begin
    case (req_op)
      OP_WRITE: new_val = req_data;
      OP_SET:   new_val = old_val | req_data;
      OP_CLEAR: new_val = old_val & ~req_data;
      default:  new_val = old_val;
    endcase
  end

  // CSR result first, then FPU flags OR'd on top so a concurrent flag event is never lost.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fcsr_nxt[w] = fcsr[w];
      if (wr_en && req_wid == NW_BITS'(w)) begin
        case (req_addr)
          A_FFLAGS: fcsr_nxt[w][4:0] = new_val[4:0];
          A_FRM:    fcsr_nxt[w][7:5] = new_val[2:0];
          A_FCSR:   fcsr_nxt[w]      = new_val[7:0];
          default:  ;
        endcase
      end
      if (fflags_valid && fflags_wid == NW_BITS'(w))
        fcsr_nxt[w][4:0] = fcsr_nxt[w][4:0] | fflags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle       <= '0;
      instret     <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        fcsr[w]     <= '0;
        mscratch[w] <= '0;
        mepc[w]     <= '0;
        cyc_hi[w]   <= '0;
        ins_hi[w]   <= '0;
      end
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_wid     <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      if (busy)      cycle   <= cycle + CTR_WIDTH'(1);
      if (cmt_valid) instret <= instret + CTR_WIDTH'(cmt_size);

      for (int w = 0; w < NUM_WARPS; w++)
        fcsr[w] <= fcsr_nxt[w];

      if (wr_en && req_addr == A_MSCRATCH) mscratch[req_wid] <= new_val;
      if (wr_en && req_addr == A_MEPC)     mepc[req_wid]     <= new_val;

      // A lo read snapshots the upper counter bits so the following hi read is coherent.
      if (accept && !illegal && req_addr == A_CYCLE)   cyc_hi[req_wid] <= cycle[CTR_WIDTH-1:32];
      if (accept && !illegal && req_addr == A_INSTRET) ins_hi[req_wid] <= instret[CTR_WIDTH-1:32];

      if (accept) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= illegal ? 32'd0 : old_val;
        rsp_wid     <= req_wid;
        rsp_illegal <= illegal;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vx_csr_bank.sv
module tb_vx_csr_bank;

  localparam int  NW   = 4;
  localparam int  CID  = 2;
  localparam longint unsigned CMASK = (64'd1 << 48) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [1:0]  req_wid;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_wid;
  logic        rsp_illegal;
  logic        fflags_valid;
  logic [1:0]  fflags_wid;
  logic [4:0]  fflags;
  logic        cmt_valid;
  logic [32:0] cmt_size;
  logic        busy;
  logic [1:0]  frm_wid;
  logic [2:0]  frm;

  vx_csr_bank #(.CORE_ID(CID), .NUM_WARPS(NW), .NUM_THREADS(4), .CTR_WIDTH(48), .CMT_SIZE_W(33)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wid(req_wid), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_wid(rsp_wid),
    .rsp_illegal(rsp_illegal),
    .fflags_valid(fflags_valid), .fflags_wid(fflags_wid), .fflags(fflags),
    .cmt_valid(cmt_valid), .cmt_size(cmt_size), .busy(busy),
    .frm_wid(frm_wid), .frm(frm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with rsp_ready high; checks the response one cycle later.
  task automatic txn(input logic [1:0] op, input logic [11:0] a, input logic [1:0] w,
                     input logic [31:0] d, input logic [31:0] exp, input logic ill, input string name);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wid = w; req_data = d;
    tick();
    req_valid = 1'b0;
    chk({name, ".valid"}, rsp_valid, 1);
    chk({name, ".data"}, rsp_data, exp);
    chk({name, ".illegal"}, rsp_illegal, ill);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_fcsr [NW];
  logic [31:0] m_msc  [NW];
  logic [31:0] m_mepc [NW];
  logic [15:0] m_clat [NW];
  logic [15:0] m_ilat [NW];
  longint unsigned m_cyc, m_ins;
  logic        m_rv, m_ri;
  logic [31:0] m_rd;
  logic [1:0]  m_rw;

  task automatic m_clear();
    for (int w = 0; w < NW; w++) begin
      m_fcsr[w] = 0; m_msc[w] = 0; m_mepc[w] = 0; m_clat[w] = 0; m_ilat[w] = 0;
    end
    m_cyc = 0; m_ins = 0; m_rv = 0; m_ri = 0; m_rd = 0; m_rw = 0;
  endtask

  task automatic m_access(input logic [1:0] op, input logic [11:0] a, input int w,
                          input logic [31:0] d, output logic [31:0] rd, output logic ill);
    logic [31:0] old, nv;
    bit known, ro, modify;
    known = 1; ro = 0; old = 0;
    case (a)
      12'h001: old = 32'(m_fcsr[w] % 32);
      12'h002: old = 32'(m_fcsr[w] / 32);
      12'h003: old = 32'(m_fcsr[w]);
      12'h340: old = m_msc[w];
      12'h341: old = m_mepc[w];
      12'hC00: begin ro = 1; old = 32'(m_cyc); end
      12'hC80: begin ro = 1; old = 32'(m_clat[w]); end
      12'hC02: begin ro = 1; old = 32'(m_ins); end
      12'hC82: begin ro = 1; old = 32'(m_ilat[w]); end
      12'hCC0: begin ro = 1; old = 4; end
      12'hCC1: begin ro = 1; old = NW; end
      12'hCC3: begin ro = 1; old = 32'(w); end
      12'hCC4: begin ro = 1; old = 32'(CID * NW + w); end
      12'hCC5: begin ro = 1; old = CID; end
      default: known = 0;
    endcase
    modify = (op == 1) || (op != 0 && d != 0);
    ill = !known || (ro && modify);
    rd = ill ? 32'd0 : old;
    if (ill) return;
    nv = (op == 1) ? d : (op == 2) ? (old | d) : (old & ~d);
    if (modify) begin
      case (a)
        12'h001: m_fcsr[w] = 8'((m_fcsr[w] / 32) * 32 + nv % 32);
        12'h002: m_fcsr[w] = 8'((nv % 8) * 32 + m_fcsr[w] % 32);
        12'h003: m_fcsr[w] = 8'(nv % 256);
        12'h340: m_msc[w]  = nv;
        12'h341: m_mepc[w] = nv;
        default: ;
      endcase
    end
    if (a == 12'hC00) m_clat[w] = 16'(m_cyc >> 32);
    if (a == 12'hC02) m_ilat[w] = 16'(m_ins >> 32);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [1:0]  wid;
    logic [31:0] d;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  vec_t tbl [24];

  initial begin
    logic [11:0] addrs [15];
    logic [31:0] rd;
    logic        ill;
    logic        acc;

    tbl[0]  = '{2'd0, 12'hCC1, 2'd1, 32'h0,        32'd4,        1'b0};
    tbl[1]  = '{2'd0, 12'hCC4, 2'd1, 32'h0,        32'd9,        1'b0};
    tbl[2]  = '{2'd1, 12'h003, 2'd0, 32'hE3,       32'h0,        1'b0};
    tbl[3]  = '{2'd2, 12'h001, 2'd0, 32'h04,       32'h03,       1'b0};
    tbl[4]  = '{2'd3, 12'h002, 2'd0, 32'h1,        32'h7,        1'b0};
    tbl[5]  = '{2'd0, 12'h003, 2'd0, 32'h0,        32'hC7,       1'b0};
    tbl[6]  = '{2'd0, 12'h003, 2'd1, 32'h0,        32'h0,        1'b0};
    tbl[7]  = '{2'd1, 12'hC00, 2'd0, 32'h5,        32'h0,        1'b1};
    tbl[8]  = '{2'd0, 12'h7FF, 2'd0, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{2'd2, 12'hC00, 2'd0, 32'h0,        32'h0,        1'b0};
    tbl[10] = '{2'd0, 12'hC00, 2'd0, 32'h0,        32'h0,        1'b0};
    tbl[11] = '{2'd0, 12'hCC0, 2'd0, 32'h0,        32'd4,        1'b0};
    tbl[12] = '{2'd0, 12'hCC5, 2'd3, 32'h0,        32'd2,        1'b0};
    tbl[13] = '{2'd0, 12'hCC3, 2'd3, 32'h0,        32'd3,        1'b0};
    tbl[14] = '{2'd1, 12'h340, 2'd2, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[15] = '{2'd0, 12'h340, 2'd2, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[16] = '{2'd0, 12'h340, 2'd1, 32'h0,        32'h0,        1'b0};
    tbl[17] = '{2'd3, 12'hCC1, 2'd0, 32'h0,        32'd4,        1'b0};
    tbl[18] = '{2'd2, 12'hCC1, 2'd0, 32'h1,        32'h0,        1'b1};
    tbl[19] = '{2'd1, 12'h341, 2'd3, 32'h12345678, 32'h0,        1'b0};
    tbl[20] = '{2'd3, 12'h341, 2'd3, 32'h0000FFFF, 32'h12345678, 1'b0};
    tbl[21] = '{2'd0, 12'h341, 2'd3, 32'h0,        32'h12340000, 1'b0};
    tbl[22] = '{2'd1, 12'h002, 2'd1, 32'hFD,       32'h0,        1'b0};
    tbl[23] = '{2'd0, 12'h003, 2'd1, 32'h0,        32'hA0,       1'b0};

    addrs = '{12'h001, 12'h002, 12'h003, 12'h340, 12'h341, 12'hC00, 12'hC80, 12'hC02,
              12'hC82, 12'hCC0, 12'hCC1, 12'hCC3, 12'hCC4, 12'hCC5, 12'h7FF};

    // Reset; a request presented during reset must be discarded.
    reset = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_addr = 12'hCC1; req_wid = 2'd0;
    req_data = 32'd0; rsp_ready = 1'b1; fflags_valid = 1'b0; fflags_wid = 2'd0; fflags = 5'd0;
    cmt_valid = 1'b0; cmt_size = 33'd0; busy = 1'b0; frm_wid = 2'd0;
    tick();
    tick();
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_data", rsp_data, 0);
    chk("reset.rsp_illegal", rsp_illegal, 0);
    chk("reset.frm", frm, 0);
    reset = 1'b0; req_valid = 1'b0;
    tick();
    chk("reset.dropped", rsp_valid, 0);

    // Table, applied back to back (one accept per cycle).
    frm_wid = 2'd1;
    for (int i = 0; i < 24; i++) begin
      req_valid = 1'b1; req_op = tbl[i].op; req_addr = tbl[i].addr;
      req_wid = tbl[i].wid; req_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d.req_ready", i), req_ready, 1);
      if (i == 22) chk("frm.no_bypass", frm, 0);
      tick();
      chk($sformatf("tbl%0d.valid", i), rsp_valid, 1);
      chk($sformatf("tbl%0d.data", i), rsp_data, tbl[i].exp);
      chk($sformatf("tbl%0d.illegal", i), rsp_illegal, tbl[i].ill);
      chk($sformatf("tbl%0d.wid", i), rsp_wid, tbl[i].wid);
    end
    req_valid = 1'b0;
    chk("frm.w1", frm, 5);
    frm_wid = 2'd0; #1;
    chk("frm.w0", frm, 6);
    frm_wid = 2'd3; #1;
    chk("frm.w3", frm, 0);
    tick();
    chk("idle.rsp_valid", rsp_valid, 0);

    // FPU flags in the same cycle as a FFLAGS write to the same warp.
    fflags_valid = 1'b1; fflags_wid = 2'd2; fflags = 5'h01;
    txn(2'd1, 12'h001, 2'd2, 32'h10, 32'h0, 1'b0, "ff.write");
    fflags_valid = 1'b0;
    txn(2'd0, 12'h001, 2'd2, 32'h0, 32'h11, 1'b0, "ff.read");
    txn(2'd0, 12'h003, 2'd2, 32'h0, 32'h11, 1'b0, "ff.fcsr");

    // Counters and hi/lo coherence.
    do_reset();
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    cmt_valid = 1'b1; cmt_size = 33'd3;
    repeat (2) tick();
    cmt_valid = 1'b0;
    txn(2'd0, 12'hC02, 2'd0, 32'h0, 32'd6, 1'b0, "ctr.instret");
    txn(2'd0, 12'hC00, 2'd0, 32'h0, 32'd5, 1'b0, "ctr.cycle");
    cmt_valid = 1'b1; cmt_size = 33'hFFFF_FFF9;
    tick();
    cmt_size = 33'd1;
    txn(2'd0, 12'hC02, 2'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, "carry.lo");
    cmt_valid = 1'b0;
    txn(2'd0, 12'hC82, 2'd0, 32'h0, 32'h0, 1'b0, "carry.hi_latched");
    txn(2'd0, 12'hC02, 2'd0, 32'h0, 32'h0, 1'b0, "carry.lo2");
    txn(2'd0, 12'hC82, 2'd0, 32'h0, 32'h1, 1'b0, "carry.hi2");
    txn(2'd0, 12'hC82, 2'd1, 32'h0, 32'h0, 1'b0, "carry.hi_w1");
    txn(2'd1, 12'hC00, 2'd0, 32'h7, 32'h0, 1'b1, "ro.write");
    txn(2'd0, 12'hC00, 2'd0, 32'h0, 32'd5, 1'b0, "ro.unaffected");
    txn(2'd2, 12'hC02, 2'd0, 32'h0, 32'h0, 1'b0, "ro.set0");

    // Response stall with a second request pending.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 12'hCC1; req_wid = 2'd0; req_data = 32'd0;
    tick();
    chk("stall.first_valid", rsp_valid, 1);
    req_op = 2'd1; req_addr = 12'h340; req_data = 32'h55;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d.req_ready", k), req_ready, 0);
      tick();
      chk($sformatf("stall%0d.valid", k), rsp_valid, 1);
      chk($sformatf("stall%0d.data", k), rsp_data, 4);
    end
    rsp_ready = 1'b1;
    #1;
    chk("stall.release_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("stall.second_valid", rsp_valid, 1);
    chk("stall.second_data", rsp_data, 0);
    txn(2'd0, 12'h340, 2'd0, 32'h0, 32'h55, 1'b0, "stall.once");

    // Reset while stalled.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 2'd0; req_addr = 12'hCC1;
    tick();
    req_op = 2'd1; req_addr = 12'h340; req_data = 32'h99;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_stall.valid", rsp_valid, 0);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("rst_stall.dropped", rsp_valid, 0);
    txn(2'd0, 12'h340, 2'd0, 32'h0, 32'h0, 1'b0, "rst_stall.cleared");

    // Randomized traffic against the reference model.
    do_reset();
    m_clear();
    for (int c = 0; c < 1500; c++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_op       = 2'($urandom_range(0, 3));
      req_addr     = addrs[$urandom_range(0, 14)];
      if ($urandom_range(0, 15) == 0) req_addr = 12'($urandom);
      req_wid      = 2'($urandom_range(0, 3));
      req_data     = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      rsp_ready    = ($urandom_range(0, 3) != 0);
      busy         = 1'($urandom_range(0, 1));
      cmt_valid    = 1'($urandom_range(0, 1));
      cmt_size     = ($urandom_range(0, 31) == 0) ? 33'($urandom) * 2 : 33'($urandom_range(0, 7));
      fflags_valid = 1'($urandom_range(0, 1));
      fflags_wid   = 2'($urandom_range(0, 3));
      fflags       = 5'($urandom);
      frm_wid      = 2'($urandom_range(0, 3));
      #1;
      chk("rnd.req_ready", req_ready, !m_rv || rsp_ready);
      acc = req_valid && (!m_rv || rsp_ready);
      if (acc) begin
        m_access(req_op, req_addr, int'(req_wid), req_data, rd, ill);
        m_rd = rd; m_ri = ill; m_rw = req_wid; m_rv = 1;
      end else if (rsp_ready) begin
        m_rv = 0;
      end
      if (fflags_valid) m_fcsr[fflags_wid] = m_fcsr[fflags_wid] | {3'd0, fflags};
      if (busy) m_cyc = (m_cyc + 1) & CMASK;
      if (cmt_valid) m_ins = (m_ins + 64'(cmt_size)) & CMASK;
      tick();
      chk("rnd.rsp_valid", rsp_valid, m_rv);
      if (m_rv) begin
        chk("rnd.rsp_data", rsp_data, m_rd);
        chk("rnd.rsp_illegal", rsp_illegal, m_ri);
        chk("rnd.rsp_wid", rsp_wid, m_rw);
      end
      chk("rnd.frm", frm, m_fcsr[frm_wid] / 32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_csr_bank.md
Name: VX_csr_bank

Overview:
Next-generation per-core CSR storage. It generalises the fixed CSR data block in four ways:
- warp count and counter width are parametrised;
- requests arrive over a valid/ready handshake with a registered response;
- CSRRW/CSRRS/CSRRC read-modify-write is atomic;
- 64-bit counters get hi/lo snapshot coherence.

It sits between the CSR unit's issue stage and its writeback, and also serves the FPU's rounding-mode lookup.

Parameters:
CORE_ID, 0, global core index returned by GCID/GWID
NUM_WARPS, 4, number of warps holding private CSRs (>=1)
NUM_THREADS, 4, value returned by CSR_NT
CTR_WIDTH, 48, implemented width of the cycle/instret counters (33..64); bits above it read as 0
CMT_SIZE_W, 3, width of commit_size

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_op  in  2  0=READ 1=WRITE 2=SET 3=CLEAR
req_addr  in  12  CSR address
req_wid  in  NW_BITS  requesting warp
req_data  in  32  write/set/clear operand
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_data  out  32  CSR value before modification
rsp_wid  out  NW_BITS  warp of response
rsp_illegal  out  1  address unknown, or modify op on a read-only CSR
fflags_valid  in  1  FPU exception flags valid
fflags_wid  in  NW_BITS  warp of FPU flags
fflags  in  5  flags to OR-accumulate
cmt_valid  in  1  commit event
cmt_size  in  CMT_SIZE_W  instructions retired this cycle
busy  in  1  core active; cycle counter enable
frm_wid  in  NW_BITS  FPU rounding-mode lookup warp
frm  out  3  combinational frm of warp frm_wid

Behaviour:
Storage:
- Per warp: fcsr (8b: frm[7:5], fflags[4:0]), mscratch (0x340), mepc (0x341), cyc_hi_latch, ins_hi_latch.
- Global: cycle, instret (CTR_WIDTH bits each).

Reset:
- All storage is cleared to 0.
- rsp_valid=0, rsp_data=0, rsp_illegal=0.
- A request accepted in the reset cycle is discarded.

Handshake:
- req_ready = ~rsp_valid | rsp_ready.
- Latency is exactly 1 cycle from accept to rsp_valid.
- rsp_* hold stable while rsp_valid & ~rsp_ready.
- Back-to-back throughput is 1 request per cycle.

Read-modify-write:
- rsp_data returns the old value.
- The new value is: WRITE = d; SET = old|d; CLEAR = old&~d.
- The update commits on the accept edge.
- A modify op is suppressed when req_op is SET/CLEAR and d==0 (RISC-V rs1=x0 rule). In that case it is a pure read and is legal on read-only CSRs.

Read-write addresses:
- FFLAGS 0x001 (5b), FRM 0x002 (3b), FCSR 0x003 (8b).
- Unused upper bits of the operand are ignored; upper bits read as 0.

Read-only addresses:
- CYCLE 0xC00, CYCLE_H 0xC80, INSTRET 0xC02, INSTRET_H 0xC82.
- NT 0xCC0 = NUM_THREADS, NW 0xCC1 = NUM_WARPS, WTID/LWID 0xCC3 = wid, GWID 0xCC4 = CORE_ID*NUM_WARPS+wid, GCID 0xCC5 = CORE_ID.

Illegal requests:
- An unknown address, or an effective modify on a read-only CSR, gives rsp_illegal=1 and rsp_data=0.
- No state changes.

Hi/lo coherence:
- A read of CYCLE (or INSTRET) stores counter[CTR_WIDTH-1:32] into that warp's hi latch.
- CYCLE_H (or INSTRET_H) returns the latch, zero-extended.
- The latch persists until the next lo read by the same warp; reset value is 0.

Counters:
- cycle += 1 when busy.
- instret += cmt_size when cmt_valid.
- Both wrap modulo 2^CTR_WIDTH.
- Counters update every cycle regardless of handshake; the value sampled is the pre-edge value.

Concurrent fflags:
- fcsr[fflags_wid].fflags |= fflags.
- If the same cycle carries an accepted FFLAGS or FCSR modify to the same warp, final fflags = CSR result | fflags. FPU flags are never lost.

frm:
- Reflects a write only after the accept edge. There is no bypass.

Test Plan:
- Reset, then READ NW, GWID with CORE_ID=2, wid=1, NUM_WARPS=4 -> rsp 4, 9; rsp_illegal=0; exactly 1-cycle latency.
- WRITE FCSR=0xE3 on w0, then SET FFLAGS 0x04, then CLEAR FRM 0x1 -> rsp 0x00, 0x03, 0x7; final FCSR=0xC7; frm(w0)=6; w1 still 0.
- fflags_valid w2 flags=0x01 in the same cycle as accepted WRITE FFLAGS=0x10 on w2 -> FFLAGS reads 0x11.
- Hold busy 5 cycles, cmt_valid with cmt_size=3 twice -> INSTRET=6, CYCLE=5; force cycle=0x0_FFFF_FFFF, read CYCLE then CYCLE_H across a carry -> CYCLE_H returns the latched 0x0, not 0x1.
- WRITE to CYCLE, and READ of 0x7FF -> rsp_illegal=1, rsp_data=0, counters unaffected; SET CYCLE with d=0 -> legal read.
- Hold rsp_ready=0 for 3 cycles with a second request pending -> req_ready=0, rsp stable, second request accepted on release; assert reset mid-stall -> rsp_valid=0 next cycle, pending request dropped.
